seq_detect_param: RTL and testbench
===================================

# seq_detect_param

Parametrised serial pattern detector driving the board's active-low 7-segment digit and detect output. It samples the serial input `x` once per internal divider tick and compares the incoming bits against a pattern loaded at run time, in overlapping or non-overlapping mode. It shows match progress (0..PAT_W) on the digit and keeps a saturating match count. It replaces the fixed 4-state, fixed-pattern detector: the pattern, its length and the slow-clock period are now parameters, and the divided clock is no longer used as a clock.

## Interface
- `PAT_W`, default 4: pattern length in bits, legal range 2..8.
- `PAT_RST`, default 4'b0111: pattern after reset. Its MSB is the first bit expected.
- `DIV`, default 20000000: `clk` cycles per sample tick, ≥2. Use 4 in simulation.
- `CNT_W`, default 8: match counter width.
- `clk`, in, 1: single clock, the Sys_Clk0 domain. Everything is synchronous to its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `x`, in, 1: serial data. Sampled only on tick edges.
- `load`, in, 1: one-cycle strobe. Loads `pat_in` and restarts detection.
- `pat_in`, in, PAT_W: new pattern. MSB is the first bit expected.
- `overlap`, in, 1: 1 = overlapping matches allowed; 0 = detection restarts after each match.
- `cnt_clr`, in, 1: clears `match_cnt`.
- `detect`, out, 1: one-`clk` pulse on the edge that completes a match.
- `y`, out, 1: active-low match flag. Low from the matching tick until the next tick.
- `a,b,c,d,e,f,g`, out, 1 each: active-low segments showing the progress digit.
- `match_cnt`, out, CNT_W: saturating count of matches.

## Operation
- **Tick divider**
  - `div_cnt` counts 0..DIV-1 and wraps.
  - `tick` = (`div_cnt` == DIV-1). It is an enable; nothing is clocked by it.
- **Sample state**
  - `hist[PAT_W-1:0]` is a shift register. On tick: `hist <= {hist[PAT_W-2:0], x}`, so the newest bit is `hist[0]`.
  - `valid` counts bits sampled since the last restart, saturating at PAT_W.
- **Match**
  - Evaluated on the post-shift values of `hist`/`valid`.
  - Match when `valid_next` == PAT_W and `hist_next` == `pat`.
- **Progress**, registered on each tick:
  - PAT_W on a match.
  - Otherwise the largest k in 0..min(`valid_next`, PAT_W-1) with `hist_next[k-1:0]` == `pat[PAT_W-1:PAT_W-k]`.
  - Failing bits therefore fall back to the longest matching prefix.
- **On a match**
  - `detect` = 1 for that cycle.
  - `y` <= 0.
  - `match_cnt` increments, saturating at all-ones.
  - If `overlap` = 0, `valid` <= 0. If 1, `valid` stays PAT_W.
- **On a tick without a match**: `y` <= 1.
- **Display**: `{a..g}` decodes the registered progress:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000
- **Load**
  - Effects: `pat` <= `pat_in`, `valid` <= 0, progress <= 0, `y` <= 1.
  - `match_cnt` is kept.
  - `div_cnt` keeps running.
  - When `load` and `tick` coincide, `load` wins: the sample is dropped and `detect` stays 0.
- **cnt_clr**: `match_cnt` <= 0. With a simultaneous match, `match_cnt` <= 1.
- **Reset values**, asynchronous:
  - `div_cnt`=0, `hist`=0, `valid`=0, progress=0, `pat`=PAT_RST.
  - `detect`=0, `y`=1, `{a..g}`=0000001, `match_cnt`=0.
- **Reset mid-stream** discards partial progress; the first tick after release is a fresh bit 1.

## Timing
- First tick after reset release occurs at the DIV-th rising edge.
- Sample-to-output latency: 1 `clk`.
  - `x` is captured on the tick edge.
  - Progress, segments, `y`, `detect` and `match_cnt` are all valid after that same edge, together.
- `detect` width: exactly 1 `clk`.
- Between ticks no registered output changes, except through `load`, `cnt_clr` or `rst`.
- `load`/`cnt_clr` take effect on the edge they are sampled. No handshake is used; one strobe gives one action.
- `x` must be stable around tick edges. No synchroniser is included; an external synchroniser is required for switch inputs.

## Test plan
- **Reset**: assert `rst` mid-stream → in the same cycle `y`=1, segments=0000001, `match_cnt`=0, `detect`=0. The first match afterwards needs 4 fresh bits.
- **Default pattern**: DIV=4, pattern 0111, overlap=0, x = 0,1,1,1 →
  - progress 1,2,3,4; segments end at 1001100.
  - `detect` pulses once at tick 4; `y` is low for 4 clk; `match_cnt`=1.
- **Fallback**: pattern 0111, x = 0,1,0,1,1,1 → progress 1,2,1,2,3,4; exactly one detect.
- **Overlap**: load 0101, x = 0,1,0,1,0,1 →
  - overlap=1: detects at ticks 4 and 6, `match_cnt`=2.
  - overlap=0: detect at tick 4 only; progress after tick 6 = 2.
- **Load collision**: assert `load`=1 (pat_in=0011) on a tick edge mid-pattern → no detect, progress 0. Then x=0,0,1,1 → detect.
- **Counter**: CNT_W=2, 5 matches → `match_cnt`=3 (saturated). Then `cnt_clr` coincident with a match → `match_cnt`=1.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a run-time loadable pattern. Bits are sampled on a
// divided tick enable, and match progress is shown on an active-low 7-segment digit.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b0111,
    parameter int               DIV     = 20000000,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             detect,
    output logic             y,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             e,
    output logic             f,
    output logic             g,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int         DW     = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [3:0] PAT_W4 = 4'(PAT_W);

    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       prog_q, prog_d;
    logic             y_q, y_d;
    logic             detect_q, detect_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             tick;
    logic [PAT_W-1:0] hist_shift;
    logic [3:0]       valid_shift;
    logic             match;
    logic [PAT_W-1:0] mask;
    logic [3:0]       prefix_len;
    logic [6:0]       seg;

    always_comb begin
        tick        = (div_cnt_q == DW'(DIV - 1));
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        hist_shift  = {hist_q[PAT_W-2:0], x};
        valid_shift = (valid_q == PAT_W4) ? valid_q : valid_q + 4'd1;
        match       = (valid_shift == PAT_W4) && (hist_shift == pat_q);

        // Longest k: the newest k bits equal the first k pattern bits.
        mask       = '0;
        prefix_len = '0;
        for (int k = 1; k < PAT_W; k++) begin
            mask = {PAT_W{1'b1}} >> (PAT_W - k);
            if ((4'(k) <= valid_shift) && (((hist_shift ^ (pat_q >> (PAT_W - k))) & mask) == '0))
                prefix_len = 4'(k);
        end
    end

    always_comb begin
        hist_d   = hist_q;
        valid_d  = valid_q;
        prog_d   = prog_q;
        pat_d    = pat_q;
        y_d      = y_q;
        detect_d = 1'b0;
        cnt_d    = cnt_q;

        // A load on a tick edge drops that sample entirely.
        if (load) begin
            pat_d   = pat_in;
            valid_d = '0;
            prog_d  = '0;
            y_d     = 1'b1;
        end else if (tick) begin
            hist_d  = hist_shift;
            valid_d = valid_shift;
            if (match) begin
                prog_d   = PAT_W4;
                y_d      = 1'b0;
                detect_d = 1'b1;
                if (!overlap) valid_d = '0;
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else begin
                prog_d = prefix_len;
                y_d    = 1'b1;
            end
        end

        if (cnt_clr) cnt_d = (!load && tick && match) ? CNT_W'(1) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            hist_q    <= '0;
            pat_q     <= PAT_RST;
            valid_q   <= '0;
            prog_q    <= '0;
            y_q       <= 1'b1;
            detect_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            hist_q    <= hist_d;
            pat_q     <= pat_d;
            valid_q   <= valid_d;
            prog_q    <= prog_d;
            y_q       <= y_d;
            detect_q  <= detect_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        case (prog_q)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            default: seg = 7'b1111111;
        endcase
    end

    assign {a, b, c, d, e, f, g} = seg;
    assign y         = y_q;
    assign detect    = detect_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed and random bench for seq_detect_param (DIV=4, CNT_W=2) with a
// bit-queue reference model of prefix matching.
module tb_seq_detect_param;

    localparam int PAT_W = 4;
    localparam int DIV   = 4;
    localparam int CNT_W = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             x = 1'b0;
    logic             load = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic             overlap = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             detect, y, a, b, c, d, e, f, g;
    logic [CNT_W-1:0] match_cnt;
    logic [6:0]       segs;
    assign segs = {a, b, c, d, e, f, g};

    seq_detect_param #(
        .PAT_W(PAT_W), .PAT_RST(4'b0111), .DIV(DIV), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .load(load), .pat_in(pat_in),
        .overlap(overlap), .cnt_clr(cnt_clr), .detect(detect), .y(y),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .match_cnt(match_cnt)
    );

    // ---------------- reference model ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ph       = 0;      // rising edges since reset release, mod DIV
    bit         mq[$];             // bits sampled since the last restart
    logic [3:0] m_pat;
    int         m_prog, m_cnt;
    logic       m_y, m_det;
    logic [6:0] seg_tab [0:8];

    initial begin
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    end

    task automatic model_reset();
        mq.delete();
        m_pat = 4'b0111; m_prog = 0; m_cnt = 0; m_y = 1'b1; m_det = 1'b0;
    endtask

    task automatic model_tick(input bit bv, input bit clr);
        bit hit;
        int n;
        mq.push_back(bv);
        if (mq.size() > PAT_W) void'(mq.pop_front());
        n = mq.size();
        hit = (n == PAT_W);
        for (int i = 0; i < n; i++)
            if (hit && mq[i] != m_pat[PAT_W-1-i]) hit = 0;
        if (hit) begin
            m_prog = PAT_W; m_y = 1'b0; m_det = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt < 3) ? m_cnt + 1 : 3);
            if (!overlap) mq.delete();
        end else begin
            m_prog = 0;
            for (int k = 1; k < PAT_W && k <= n; k++) begin
                bit ok = 1;
                for (int j = 0; j < k; j++)
                    if (mq[n-k+j] != m_pat[PAT_W-1-j]) ok = 0;
                if (ok) m_prog = k;
            end
            m_y = 1'b1; m_det = 1'b0;
            if (clr) m_cnt = 0;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":detect"}, 32'(detect), 32'(m_det));
        chk({tag, ":y"}, 32'(y), 32'(m_y));
        chk({tag, ":segs"}, 32'(segs), 32'(seg_tab[m_prog]));
        chk({tag, ":cnt"}, 32'(match_cnt), 32'(m_cnt));
    endtask

    // ---------------- drivers ----------------
    task automatic clk_step();
        @(posedge clk);
        ph = (ph + 1) % DIV;
        #1;
    endtask

    // Non-tick edge: only the detect pulse may end.
    task automatic step_chk();
        clk_step();
        m_det = 1'b0;
        check_all("idle");
    endtask

    task automatic send_bit(input bit bv, input bit clr);
        while (ph != DIV - 1) step_chk();
        x = bv; cnt_clr = clr;
        clk_step();
        cnt_clr = 1'b0;
        model_tick(bv, clr);
        check_all("tick");
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i], 1'b0);
    endtask

    task automatic do_load(input logic [3:0] p, input bit collide, input bit xb);
        if (collide) begin
            while (ph != DIV - 1) step_chk();
        end else if (ph == DIV - 1) begin
            step_chk();
        end
        x = xb; load = 1'b1; pat_in = p;
        clk_step();
        load = 1'b0;
        m_pat = p; mq.delete(); m_prog = 0; m_y = 1'b1; m_det = 1'b0;
        check_all(collide ? "load_tick" : "load");
    endtask

    task automatic clear_cnt();
        if (ph == DIV - 1) step_chk();
        cnt_clr = 1'b1;
        clk_step();
        cnt_clr = 1'b0;
        m_cnt = 0; m_det = 1'b0;
        check_all("cnt_clr");
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        ph = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        ph = 0;

        // Default pattern 0111, non-overlapping
        overlap = 1'b0;
        send_bits(8'b0111, 4);
        chk("default_cnt", 32'(match_cnt), 32'd1);
        chk("default_seg", 32'(segs), 32'(7'b1001100));

        // Fallback: progress 1,2,1,2,3,4
        send_bits(8'b010111, 6);
        chk("fallback_cnt", 32'(match_cnt), 32'd2);

        // Overlapping 0101
        clear_cnt();
        overlap = 1'b1;
        do_load(4'b0101, 1'b0, 1'b0);
        send_bits(8'b010101, 6);
        chk("overlap_cnt", 32'(match_cnt), 32'd2);

        // Non-overlapping 0101
        overlap = 1'b0;
        do_load(4'b0101, 1'b0, 1'b0);
        send_bits(8'b010101, 6);
        chk("nonoverlap_seg", 32'(segs), 32'(7'b0010010));

        // Load colliding with the tick that would have completed 0111
        do_load(4'b0111, 1'b0, 1'b0);
        send_bits(8'b011, 3);
        do_load(4'b0011, 1'b1, 1'b1);
        chk("collide_det", 32'(detect), 32'd0);
        send_bits(8'b0011, 4);
        chk("collide_match_y", 32'(y), 32'd0);

        // Saturating counter, then clear coincident with a match
        do_load(4'b0111, 1'b0, 1'b0);
        clear_cnt();
        for (int i = 0; i < 5; i++) send_bits(8'b0111, 4);
        chk("cnt_sat", 32'(match_cnt), 32'd3);
        send_bits(8'b011, 3);
        send_bit(1'b1, 1'b1);
        chk("clr_with_match", 32'(match_cnt), 32'd1);

        // Reset mid-stream after a load of another pattern
        do_load(4'b1010, 1'b0, 1'b0);
        do_load(4'b0111, 1'b0, 1'b0);
        send_bits(8'b011, 3);
        step_chk();
        apply_reset();
        send_bit(1'b1, 1'b0);
        send_bits(8'b0111, 4);
        chk("post_reset_cnt", 32'(match_cnt), 32'd1);

        // Random bits, patterns, overlap mode and counter clears
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0)
                do_load(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            overlap = 1'($urandom_range(0, 1));
            send_bit(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
